// File: rtl/viterbi_traceback.sv
// Traceback back end of the rate-1/2, K=3 Viterbi decoder: it stores the node words of each
// trellis column, picks the best end state, walks the survivor flags back and emits the frame.
module viterbi_traceback #(
    parameter int NUM_COL    = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_st,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_data_in0,
    input  logic [DATA_WIDTH-1:0] i_data_in1,
    input  logic [DATA_WIDTH-1:0] i_data_in2,
    input  logic [DATA_WIDTH-1:0] i_data_in3,
    output logic [NUM_COL-1:0]    o_decoded,
    output logic                  o_done,
    output logic                  o_busy
);

    localparam int COL_W = ADDR_WIDTH - 2;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_FIND_MIN = 3'd2,
        S_TRACE    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [COL_W-1:0]      r_col;
    logic [COL_W-1:0]      r_t;
    logic [1:0]            r_cur;
    logic [NUM_COL-1:0]    r_shadow;
    logic [DATA_WIDTH-1:0] r_mem [NUM_COL*4];

    logic                  w_wr;
    logic                  w_fin;
    logic [4:0]            w_m0, w_m1, w_m2, w_m3;
    logic [4:0]            w_min01, w_min23;
    logic [1:0]            w_sel01, w_sel23, w_best;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [1:0]            w_flag;
    logic                  w_x;

    // Last-column metrics; strict compares keep the lower state index on a tie.
    assign w_m0    = r_mem[{LAST_COL, 2'd0}][6:2];
    assign w_m1    = r_mem[{LAST_COL, 2'd1}][6:2];
    assign w_m2    = r_mem[{LAST_COL, 2'd2}][6:2];
    assign w_m3    = r_mem[{LAST_COL, 2'd3}][6:2];
    assign w_sel01 = (w_m1 < w_m0) ? 2'd1 : 2'd0;
    assign w_min01 = (w_m1 < w_m0) ? w_m1 : w_m0;
    assign w_sel23 = (w_m3 < w_m2) ? 2'd3 : 2'd2;
    assign w_min23 = (w_m3 < w_m2) ? w_m3 : w_m2;
    assign w_best  = (w_min23 < w_min01) ? w_sel23 : w_sel01;

    // Only flag 2'b10 selects the odd predecessor; ties and invalid flags fall back to x=0.
    assign w_rd_addr = {r_t, r_cur};
    assign w_flag    = r_mem[w_rd_addr][1:0];
    assign w_x       = (w_flag == 2'b10);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a start request overrides everything else.
    always_comb begin
        w_next = r_state;
        if (i_st) begin
            w_next = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:     w_next = S_IDLE;
                S_COLLECT:  w_next = (i_wr_en && (r_col == LAST_COL)) ? S_FIND_MIN : S_COLLECT;
                S_FIND_MIN: w_next = S_TRACE;
                S_TRACE:    w_next = (r_t == {COL_W{1'b0}}) ? S_DONE : S_TRACE;
                S_DONE:     w_next = S_IDLE;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // Output/control decode.
    always_comb begin
        w_wr  = 1'b0;
        w_fin = 1'b0;
        if (!i_st) begin
            w_wr  = (r_state == S_COLLECT) && i_wr_en;
            w_fin = (r_state == S_DONE);
        end else begin
            w_wr  = 1'b0;
            w_fin = 1'b0;
        end
    end

    // Trellis memory: one column of four node words per strobe.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[{r_col, 2'd0}] <= i_data_in0;
            r_mem[{r_col, 2'd1}] <= i_data_in1;
            r_mem[{r_col, 2'd2}] <= i_data_in2;
            r_mem[{r_col, 2'd3}] <= i_data_in3;
        end
    end

    // Column counter, traceback pointer and decoded shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col    <= {COL_W{1'b0}};
            r_t      <= {COL_W{1'b0}};
            r_cur    <= 2'd0;
            r_shadow <= {NUM_COL{1'b0}};
        end else if (i_st) begin
            r_col <= {COL_W{1'b0}};
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_wr) begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                S_FIND_MIN: begin
                    r_cur <= w_best;
                    r_t   <= LAST_COL;
                end
                S_TRACE: begin
                    r_shadow[r_t] <= r_cur[1];
                    r_cur         <= {r_cur[0], w_x};
                    if (r_t != {COL_W{1'b0}}) begin
                        r_t <= r_t - COL_W'(1);
                    end
                end
                default: begin
                    r_col <= r_col;
                end
            endcase
        end
    end

    // Registered outputs; decoded is published together with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_decoded <= {NUM_COL{1'b0}};
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_done <= w_fin;
            o_busy <= (w_next != S_IDLE);
            if (w_fin) begin
                o_decoded <= r_shadow;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed and randomized frames for viterbi_traceback, checked against a trellis-walk model.
module tb_viterbi_traceback;

    logic       clk;
    logic       rst;
    logic       st;
    logic       wr_en;
    logic [7:0] d0, d1, d2, d3;
    logic [9:0] decoded;
    logic       done;
    logic       busy;

    int         checks;
    int         failures;
    logic [7:0] fr [10][4];
    logic [9:0] exp_dec;
    logic [9:0] prev_dec;

    viterbi_traceback #(.NUM_COL(10), .DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_st       (st),
        .i_wr_en    (wr_en),
        .i_data_in0 (d0),
        .i_data_in1 (d1),
        .i_data_in2 (d2),
        .i_data_in3 (d3),
        .o_decoded  (decoded),
        .o_done     (done),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Node word with random (ignored) bit 7.
    function automatic logic [7:0] mk(input int m, input int f);
        logic [7:0] w;
        w = {1'($urandom % 2), 5'(m), 2'(f)};
        return w;
    endfunction

    // Reference: best end state, then walk predecessors {n0,x} emitting n1 per column.
    function automatic logic [9:0] model_decode();
        logic [9:0] res;
        int best, s, x, flag;
        best = 0;
        for (int k = 1; k < 4; k++)
            if (((fr[9][k] >> 2) & 31) < ((fr[9][best] >> 2) & 31)) best = k;
        s = best;
        res = '0;
        for (int c = 9; c >= 0; c--) begin
            res[c] = (s >= 2);
            flag = int'(fr[c][s] & 8'd3);
            x = (flag == 2) ? 1 : 0;
            s = (s % 2) * 2 + x;
        end
        return res;
    endfunction

    task automatic gen_random();
        for (int c = 0; c < 10; c++)
            for (int k = 0; k < 4; k++)
                fr[c][k] = 8'($urandom);
    endtask

    task automatic start_frame();
        st = 1'b1;
        tick();
        st = 1'b0;
        check("busy_after_st", 32'(busy), 32'd1);
    endtask

    task automatic send_cols(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            if ($urandom % 4 == 0) tick();
            d0 = fr[c][0]; d1 = fr[c][1]; d2 = fr[c][2]; d3 = fr[c][3];
            wr_en = 1'b1;
            tick();
            wr_en = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input logic [9:0] exp, input bit garbage);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (garbage) begin
                wr_en = 1'($urandom % 2);
                d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
            end
            tick();
            n++;
            if (n == 6) check({tag, "_busy_trace"}, 32'(busy), 32'd1);
        end
        wr_en = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd12);
        check({tag, "_decoded"}, 32'(decoded), 32'(exp));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_decoded_hold"}, 32'(decoded), 32'(exp));
    endtask

    task automatic run_frame(input string tag, input bit garbage);
        exp_dec = model_decode();
        start_frame();
        send_cols(0, 9);
        wait_done(tag, exp_dec, garbage);
    endtask

    initial begin
        int s, x;
        int u [10] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        checks = 0;
        failures = 0;
        st = 1'b0; wr_en = 1'b0; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_decoded", 32'(decoded), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // All-zero frame.
        for (int c = 0; c < 10; c++) begin
            fr[c][0] = mk(0, 1);
            for (int k = 1; k < 4; k++) fr[c][k] = mk(2, 1);
        end
        check("zero_model", 32'(model_decode()), 32'd0);
        run_frame("zero", 1'b0);

        // Known path 1,0,1,1,0,0,0,0,0,0 with random off-path flags.
        gen_random();
        s = 0;
        for (int i = 0; i < 10; i++) begin
            x = s % 2;
            s = u[i] * 2 + s / 2;
            fr[i][s] = mk(int'($urandom % 32), (x == 1) ? 2 : 1);
        end
        fr[9][0] = mk(0, int'(fr[9][0] & 8'd3));
        for (int k = 1; k < 4; k++) fr[9][k] = mk(1 + int'($urandom % 31), int'(fr[9][k] & 8'd3));
        check("path_model", 32'(model_decode()), 32'h00D);
        run_frame("path", 1'b0);

        // Tie on end state: metrics {5,3,3,7} -> state 1 wins, so decoded[9]=0.
        gen_random();
        fr[9][0] = mk(5, int'(fr[9][0] & 8'd3));
        fr[9][1] = mk(3, int'(fr[9][1] & 8'd3));
        fr[9][2] = mk(3, int'(fr[9][2] & 8'd3));
        fr[9][3] = mk(7, int'(fr[9][3] & 8'd3));
        run_frame("endtie", 1'b0);
        check("endtie_bit9", 32'(decoded[9]), 32'd0);

        // Tie flags everywhere, minimum at state 2.
        for (int c = 0; c < 10; c++)
            for (int k = 0; k < 4; k++)
                fr[c][k] = mk(int'($urandom % 32), 3);
        fr[9][0] = mk(9, 3); fr[9][1] = mk(9, 3); fr[9][2] = mk(1, 3); fr[9][3] = mk(9, 3);
        check("flagtie_model", 32'(model_decode()), 32'h200);
        run_frame("flagtie", 1'b0);

        // Random frames, one with stray wr_en during find/trace/done.
        gen_random();
        run_frame("rand0", 1'b1);
        gen_random();
        run_frame("rand1", 1'b0);
        gen_random();
        run_frame("rand2", 1'b1);

        // Abort in trace cycle 4, then a fresh frame without another st.
        prev_dec = decoded;
        gen_random();
        start_frame();
        send_cols(0, 9);
        for (int i = 0; i < 4; i++) tick();
        st = 1'b1;
        tick();
        st = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done !== 1'b0) check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_done", 32'(done), 32'd0);
        check("abort_decoded", 32'(decoded), 32'(prev_dec));
        check("abort_busy", 32'(busy), 32'd1);
        gen_random();
        exp_dec = model_decode();
        send_cols(0, 9);
        wait_done("after_abort", exp_dec, 1'b0);

        // Reset after five columns.
        gen_random();
        start_frame();
        send_cols(0, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_decoded", 32'(decoded), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        gen_random();
        run_frame("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
